// File: rtl/conv_encoder_framer_if.sv
// Handshake bundle between the bit producer, the encoder/framer and the frame consumer.
// master = producer/consumer side, slave = encoder side.
interface conv_encoder_framer_if #(
  parameter int unsigned FRAME_LEN = 7
);
  logic                   in_bit;
  logic                   in_valid;
  logic                   in_ready;
  logic [2*FRAME_LEN-1:0] dat;
  logic                   frame_valid;
  logic                   frame_ack;

  modport master (
    output in_bit, in_valid, frame_ack,
    input  in_ready, dat, frame_valid
  );

  modport slave (
    input  in_bit, in_valid, frame_ack,
    output in_ready, dat, frame_valid
  );
endinterface

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 feedforward convolutional encoder packing FRAME_LEN symbol pairs per frame.
// Optional macro TAIL_FLUSH_EN appends K-1 zero-input pairs so every frame ends in state 0.
module conv_encoder_framer #(
  parameter int unsigned    FRAME_LEN = 7,
  parameter int unsigned    K         = 3,
  parameter logic [K-1:0]   G0        = 3'b111,
  parameter logic [K-1:0]   G1        = 3'b101
) (
  input logic                 clk,
  input logic                 reset,
  conv_encoder_framer_if.slave bus
);

  localparam int          DW   = 2 * FRAME_LEN;
  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);

`ifdef TAIL_FLUSH_EN
  localparam int unsigned NData = FRAME_LEN - (K - 1);
  localparam logic [CntW-1:0] LastPair = CntW'(FRAME_LEN - 1);
`else
  localparam int unsigned NData = FRAME_LEN;
`endif
  localparam logic [CntW-1:0] LastData = CntW'(NData - 1);

  localparam logic [1:0] ACCEPT = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
`ifdef TAIL_FLUSH_EN
  localparam logic [1:0] FLUSH  = 2'd2;

  if (FRAME_LEN <= K - 1) begin : g_bad_frame_len
    $error("FRAME_LEN must exceed K-1 when tail flushing is enabled");
  end
`endif

  logic [1:0]      state_q, state_d;
  logic [K-2:0]    sr_q, sr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   dat_q, dat_d;

  logic            step;
  logic            b;
  logic [K-1:0]    sr_full;
  logic            c0, c1;

  // Encoder advances on an accepted bit, or on every flush cycle with a forced zero.
  always_comb begin
    step = 1'b0;
    b    = 1'b0;
    case (state_q)
      ACCEPT: begin
        step = bus.in_valid;
        b    = bus.in_bit;
      end
`ifdef TAIL_FLUSH_EN
      FLUSH: step = 1'b1;
`endif
      default: ;
    endcase
  end

  assign sr_full = {b, sr_q};
  assign c0      = ^(sr_full & G0);
  assign c1      = ^(sr_full & G1);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    if (step) begin
      for (int i = 0; i < int'(FRAME_LEN); i++) begin
        if (cnt_q == CntW'(i)) dat_d[DW-1-2*i -: 2] = {c0, c1};
      end
      sr_d  = sr_full[K-1:1];
      cnt_d = cnt_q + CntW'(1);
    end
    case (state_q)
      ACCEPT: begin
`ifdef TAIL_FLUSH_EN
        if (step && cnt_q == LastData) state_d = FLUSH;
`else
        if (step && cnt_q == LastData) state_d = HOLD;
`endif
      end
`ifdef TAIL_FLUSH_EN
      FLUSH: if (cnt_q == LastPair) state_d = HOLD;
`endif
      HOLD: begin
        // dat is left alone; the next frame overwrites it pair by pair.
        if (bus.frame_ack) begin
          state_d = ACCEPT;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCEPT;
      sr_q    <= '0;
      cnt_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
    end
  end

  assign bus.in_ready    = (state_q == ACCEPT);
  assign bus.frame_valid = (state_q == HOLD);
  assign bus.dat         = dat_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench for conv_encoder_framer; expected codewords are hand-encoded with G0=111, G1=101.
// Build with TAIL_FLUSH_EN defined to exercise the flush variant.
module tb_conv_encoder_framer;

  localparam int FL = 7;
`ifdef TAIL_FLUSH_EN
  localparam int          ND       = 5;
  localparam int          LAT      = 2;
  localparam logic [13:0] ONES_EXP = 14'h36A7;
`else
  localparam int          ND       = 7;
  localparam int          LAT      = 0;
  localparam logic [13:0] ONES_EXP = 14'h36AA;
`endif
  localparam logic [13:0] A_EXP = 14'h385C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_encoder_framer_if #(.FRAME_LEN(FL)) bus ();

  conv_encoder_framer #(.FRAME_LEN(FL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] pat_a    = 7'b1011000;
  logic [6:0] pat_ones = 7'b1111111;
  logic [6:0] pat_zero = 7'b0000000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Present one bit after 'gap' idle cycles; returns just after the accepting edge.
  task automatic send(input logic bv, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bit   = bv;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [6:0] bits, input int first, input int last, input bit gaps);
    for (int i = first; i < last; i++) send(bits[6-i], gaps ? (i % 4) : 0);
  endtask

  task automatic ack;
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_ack = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [13:0] exp);
    repeat (LAT) @(posedge clk);
    #1;
    check({tag, "_fv"}, 32'(bus.frame_valid), 32'd1);
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_dat"}, 32'(bus.dat), 32'(exp));
  endtask

  initial begin
    bus.in_bit    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.frame_ack = 1'b0;

    // Reset state, with inputs active during reset
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fv", 32'(bus.frame_valid), 32'd0);
    check("rst_rdy", 32'(bus.in_ready), 32'd1);
    check("rst_dat", 32'(bus.dat), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Frame A, continuous valid; frame_valid exactly one cycle after the last transfer
    send_bits(pat_a, 0, ND - 1, 1'b0);
    check("a_fv_early", 32'(bus.frame_valid), 32'd0);
    send_bits(pat_a, ND - 1, ND, 1'b0);
`ifdef TAIL_FLUSH_EN
    // Flush: a 6th bit is offered but must not be taken
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    check("flush1_rdy", 32'(bus.in_ready), 32'd0);
    check("flush1_fv", 32'(bus.frame_valid), 32'd0);
    @(negedge clk);
    check("flush2_rdy", 32'(bus.in_ready), 32'd0);
    check("flush2_fv", 32'(bus.frame_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("flush_done_fv", 32'(bus.frame_valid), 32'd1);
    check("flush_done_dat", 32'(bus.dat), 32'(A_EXP));
`else
    expect_frame("a", A_EXP);
`endif

    // HOLD ignores in_valid; dat frozen
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_dat", 32'(bus.dat), 32'(A_EXP));
      check("hold_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    ack();
    check("ack_fv", 32'(bus.frame_valid), 32'd0);
    check("ack_rdy", 32'(bus.in_ready), 32'd1);
    check("ack_dat_kept", 32'(bus.dat), 32'(A_EXP));

    // Same frame again: encoder memory must have been cleared
    send_bits(pat_a, 0, ND, 1'b0);
    expect_frame("a2", A_EXP);
    ack();

    // All ones with 0..3 idle cycles between bits
    send_bits(pat_ones, 0, ND - 1, 1'b1);
    check("ones_fv_early", 32'(bus.frame_valid), 32'd0);
    send_bits(pat_ones, ND - 1, ND, 1'b1);
    expect_frame("ones", ONES_EXP);
    ack();

    // Reset mid-frame after 4 accepted bits
    send_bits(pat_a, 0, 4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_fv", 32'(bus.frame_valid), 32'd0);
    check("midrst_dat", 32'(bus.dat), 32'd0);
    check("midrst_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    send_bits(pat_zero, 0, ND - 4, 1'b0);
    #1;
    check("midrst_cnt_cleared", 32'(bus.frame_valid), 32'd0);
    send_bits(pat_zero, ND - 4, ND, 1'b0);
    expect_frame("zero", 14'h0000);
    ack();

    // frame_ack in ACCEPT is ignored
    send_bits(pat_a, 0, 3, 1'b0);
    ack();
    check("early_ack_fv", 32'(bus.frame_valid), 32'd0);
    check("early_ack_rdy", 32'(bus.in_ready), 32'd1);
    send_bits(pat_a, 3, ND, 1'b0);
    expect_frame("early_ack", A_EXP);
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
